// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : uart_pkg                                           |
// | Description : Shared UART constants, FSM state encoding and      |
// |               parity helper for transmitter and receiver.        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data,
                                         input logic                   odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : uart_baud_cnt                                      |
// | Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while |
// |               enabled, ticks on the last count, held at zero     |
// |               while cleared.                                     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module uart_baud_cnt #(
    parameter  int CLKS_PER_BIT = 15,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count and wrap at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o  = en_i & ~clr_i & (cnt_q == CNT_LAST);
    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : uart_tx                                            |
// | Description : UART transmitter with one-entry holding register,  |
// |               optional parity and 1 or 2 stop bits.              |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   txd,
    output logic                   tx_busy,
    output logic                   tx_done
);

    localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic             PAR_ODD      = (PARITY_ODD != 0);
    localparam logic             STOP_LAST    = (STOP_BITS == 2);

    uart_state_e             state_q;
    logic [UART_DATA_W-1:0]  hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic [UART_DATA_W-1:0]  shift_q;
    logic                    par_q;
    logic [2:0]              bit_idx_q;
    logic                    stop_idx_q;
    logic                    txd_q, busy_q, done_q;

    logic                    baud_tick;
    logic [CNT_W-1:0]        baud_cnt;
    logic                    in_last_stop;
    logic                    frame_end;
    logic                    load;
    logic                    accept;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr_i   (state_q == ST_IDLE),
        .en_i    (state_q != ST_IDLE),
        .tick_o  (baud_tick),
        .count_o (baud_cnt)
    );

    assign in_last_stop = (state_q == ST_STOP) && (stop_idx_q == STOP_LAST);
    assign frame_end    = in_last_stop & baud_tick;
    // A held byte starts a frame from idle or straight after the last stop cycle.
    assign load         = hold_full_q & ((state_q == ST_IDLE) | frame_end);
    assign accept       = tx_valid & ~hold_full_q;

    // Holding register next state: a new acceptance overrides the transfer out.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    // Holding register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Frame FSM with registered line, busy and done outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Raised one cycle early so it is high during the final stop cycle.
            done_q <= in_last_stop && (baud_cnt == CNT_PRE_LAST);
            if (load) begin
                state_q    <= ST_START;
                shift_q    <= hold_q;
                par_q      <= uart_parity(hold_q, PAR_ODD);
                bit_idx_q  <= '0;
                stop_idx_q <= 1'b0;
                txd_q      <= 1'b0;
                busy_q     <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    ST_START: begin
                        if (baud_tick) begin
                            state_q <= ST_DATA;
                            txd_q   <= shift_q[0];
                        end
                    end
                    ST_DATA: begin
                        if (baud_tick) begin
                            if (bit_idx_q == 3'd7) begin
                                if (PARITY_EN != 0) begin
                                    state_q <= ST_PARITY;
                                    txd_q   <= par_q;
                                end else begin
                                    state_q    <= ST_STOP;
                                    txd_q      <= 1'b1;
                                    stop_idx_q <= 1'b0;
                                end
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                                shift_q   <= {1'b0, shift_q[UART_DATA_W-1:1]};
                                txd_q     <= shift_q[1];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (baud_tick) begin
                            state_q    <= ST_STOP;
                            txd_q      <= 1'b1;
                            stop_idx_q <= 1'b0;
                        end
                    end
                    ST_STOP: begin
                        if (baud_tick) begin
                            if (stop_idx_q == STOP_LAST) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                txd_q   <= 1'b1;
                            end else begin
                                stop_idx_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        txd_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready = ~hold_full_q;
    assign txd      = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_uart_tx                                         |
// | Description : Directed self-checking bench for uart_tx over four |
// |               parameter sets.                                    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] valid_r;
    logic [7:0] data_r [4];
    logic [3:0] txd_w, busy_w, done_w, ready_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx u_dut0 (
        .clk(clk), .n_rst(n_rst), .tx_data(data_r[0]), .tx_valid(valid_r[0]),
        .tx_ready(ready_w[0]), .txd(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
    );

    uart_tx #(.CLKS_PER_BIT(15), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .tx_data(data_r[1]), .tx_valid(valid_r[1]),
        .tx_ready(ready_w[1]), .txd(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
    );

    uart_tx #(.CLKS_PER_BIT(15), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .tx_data(data_r[2]), .tx_valid(valid_r[2]),
        .tx_ready(ready_w[2]), .txd(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
    );

    uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .n_rst(n_rst), .tx_data(data_r[3]), .tx_valid(valid_r[3]),
        .tx_ready(ready_w[3]), .txd(txd_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Follows one frame cycle by cycle starting at the next rising edge.
    // rdy_mode 0: tx_ready high throughout; 1: high on cycle 0 only (next byte waiting).
    task automatic run_frame(input int d, input logic [7:0] b, input int clks, input int pe,
                             input int po, input int sb, input int rdy_mode, input bit drop_valid);
        logic [11:0] bits;
        int          nb;
        int          n;
        int          mism     = 0;
        int          busy_err = 0;
        int          rdy_err  = 0;
        int          done_cnt = 0;
        logic        done_last = 1'b0;
        logic        rdy_exp;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        if (pe != 0) bits[9] = (^b) ^ po[0];
        nb = 9 + pe + sb;
        n  = nb * clks;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 && drop_valid) valid_r[d] = 1'b0;
            rdy_exp = (rdy_mode == 0) ? 1'b1 : (c == 0);
            if (txd_w[d] !== bits[c / clks]) mism++;
            if (busy_w[d] !== 1'b1) busy_err++;
            if (ready_w[d] !== rdy_exp) rdy_err++;
            if (done_w[d] === 1'b1) done_cnt++;
            if (c == n - 1) done_last = done_w[d];
            if (c % clks == clks - 1) begin
                check($sformatf("dut%0d byte %02h bit%0d txd errors", d, b, c / clks), mism, 0);
                mism = 0;
            end
        end
        check($sformatf("dut%0d byte %02h busy errors", d, b), busy_err, 0);
        check($sformatf("dut%0d byte %02h ready errors", d, b), rdy_err, 0);
        check($sformatf("dut%0d byte %02h done count", d, b), done_cnt, 1);
        check($sformatf("dut%0d byte %02h done at last cycle", d, b), {31'd0, done_last}, 1);
    endtask

    task automatic check_idle(input int d);
        @(posedge clk);
        #1;
        check($sformatf("dut%0d idle txd", d), {31'd0, txd_w[d]}, 1);
        check($sformatf("dut%0d idle busy", d), {31'd0, busy_w[d]}, 0);
        check($sformatf("dut%0d idle done", d), {31'd0, done_w[d]}, 0);
        check($sformatf("dut%0d idle ready", d), {31'd0, ready_w[d]}, 1);
    endtask

    task automatic send(input int d, input logic [7:0] b, input int clks, input int pe,
                        input int po, input int sb);
        @(negedge clk);
        data_r[d]  = b;
        valid_r[d] = 1'b1;
        @(posedge clk);
        #1;
        valid_r[d] = 1'b0;
        check($sformatf("dut%0d accept ready", d), {31'd0, ready_w[d]}, 0);
        check($sformatf("dut%0d latency txd", d), {31'd0, txd_w[d]}, 1);
        run_frame(d, b, clks, pe, po, sb, 0, 1'b0);
        check_idle(d);
    endtask

    initial begin
        int          pre_done;
        logic [7:0]  vec [3];
        vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'hA3;
        n_rst   = 1'b0;
        valid_r = '0;
        for (int i = 0; i < 4; i++) data_r[i] = 8'h00;

        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("dut%0d reset txd", d), {31'd0, txd_w[d]}, 1);
            check($sformatf("dut%0d reset ready", d), {31'd0, ready_w[d]}, 1);
            check($sformatf("dut%0d reset busy", d), {31'd0, busy_w[d]}, 0);
            check($sformatf("dut%0d reset done", d), {31'd0, done_w[d]}, 0);
        end
        @(negedge clk);
        n_rst = 1'b1;

        // Basic frames on the default configuration.
        send(0, 8'h55, 15, 0, 0, 1);
        for (int i = 0; i < 3; i++) send(0, vec[i], 15, 0, 0, 1);

        // Back-to-back: 0x34 is offered while 0x12 waits, then held until accepted.
        @(negedge clk);
        data_r[0]  = 8'h12;
        valid_r[0] = 1'b1;
        @(posedge clk);
        #1;
        data_r[0] = 8'h34;
        check("b2b first accept ready", {31'd0, ready_w[0]}, 0);
        run_frame(0, 8'h12, 15, 0, 0, 1, 1, 1'b1);
        run_frame(0, 8'h34, 15, 0, 0, 1, 0, 1'b0);
        check_idle(0);

        // Reset in the middle of a frame, then a clean frame right after release.
        @(negedge clk);
        data_r[0]  = 8'hA5;
        valid_r[0] = 1'b1;
        @(posedge clk);
        #1;
        valid_r[0] = 1'b0;
        pre_done = 0;
        for (int c = 0; c <= 70; c++) begin
            @(posedge clk);
            #1;
            if (done_w[0] === 1'b1) pre_done++;
        end
        check("abort pre-reset txd", {31'd0, txd_w[0]}, 0);
        check("abort no done", pre_done, 0);
        #2;
        n_rst = 1'b0;
        #1;
        check("abort async txd", {31'd0, txd_w[0]}, 1);
        check("abort busy", {31'd0, busy_w[0]}, 0);
        check("abort ready", {31'd0, ready_w[0]}, 1);
        check("abort done", {31'd0, done_w[0]}, 0);
        @(negedge clk);
        @(negedge clk);
        n_rst      = 1'b1;
        data_r[0]  = 8'h3C;
        valid_r[0] = 1'b1;
        @(posedge clk);
        #1;
        valid_r[0] = 1'b0;
        check("post-reset first edge accept", {31'd0, ready_w[0]}, 0);
        run_frame(0, 8'h3C, 15, 0, 0, 1, 0, 1'b0);
        check_idle(0);

        // Parity variants and the short-bit, two-stop-bit variant.
        send(1, 8'h07, 15, 1, 0, 1);
        send(2, 8'h07, 15, 1, 1, 1);
        send(3, 8'h80, 2, 0, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
